// File: rtl/egr_tagring_tx.sv
// egr_tagring_tx
// Transmit end of the egress tag ring. Tags from the GMM-side producer are
// buffered in a small FIFO and injected into empty ring slots. Occupied
// upstream slots always pass through with one register stage. A starvation
// tracker raises hold_req when the head tag has been blocked for too long.
//
// Ports:
//   cclk, rst_n          core clock, synchronous active-low reset
//   in_valid/in_ready    producer handshake; in_dst/in_tag carry the tag
//   ring_in_*            upstream ring slot (valid, destination, payload)
//   ring_out_*           downstream ring slot, registered
//   hold_req             asks upstream to issue an empty slot
//   fifo_level           number of buffered tags
//   inj_cnt              wrapping count of injected tags
module egr_tagring_tx #(
    parameter int TAG_W      = 32,
    parameter int DST_W      = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic                              cclk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DST_W-1:0]                  in_dst,
    input  logic [TAG_W-1:0]                  in_tag,
    input  logic                              ring_in_valid,
    input  logic [DST_W-1:0]                  ring_in_dst,
    input  logic [TAG_W-1:0]                  ring_in_tag,
    output logic                              ring_out_valid,
    output logic [DST_W-1:0]                  ring_out_dst,
    output logic [TAG_W-1:0]                  ring_out_tag,
    output logic                              hold_req,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [15:0]                       inj_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int SC_W  = $clog2(STARVE_MAX+1);
    localparam int ENT_W = DST_W + TAG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [DST_W-1:0] out_dst_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [15:0]      inj_cnt_q;
    state_t           state_q, state_d;
    logic [SC_W-1:0]  sc_q, sc_d;

    logic             do_enq;
    logic             do_pop;
    logic [ENT_W-1:0] head;

    // in_ready is the registered "not full" flag, so a pop in the same cycle
    // never lets a full FIFO accept: there is deliberately no full-bypass.
    assign do_enq = in_valid && in_ready_q;
    // Injection only uses a slot upstream left empty; occupied slots always win.
    assign do_pop = !ring_in_valid && (level_q != '0);
    assign head   = mem_q[rd_ptr_q];

    // Next FIFO occupancy: simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_d = level_q;
        if (do_enq && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_enq && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Starvation FSM. The counter only advances while a head tag exists and
    // the upstream slot is occupied; once in HOLD it freezes until the head
    // finally gets injected.
    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (do_enq) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (do_pop) begin
                    sc_d    = '0;
                    state_d = (level_d == '0) ? IDLE : WAIT;
                end else if (ring_in_valid) begin
                    sc_d = sc_q + 1'b1;
                    if (sc_q == SC_W'(STARVE_MAX - 1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (do_pop) begin
                    sc_d    = '0;
                    state_d = (level_d == '0) ? IDLE : WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                sc_d    = '0;
            end
        endcase
    end

    // FIFO storage has no reset: stale entries are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge cclk) begin
        if (do_enq) begin
            mem_q[wr_ptr_q] <= {in_dst, in_tag};
        end
    end

    // Control registers and the registered ring slot. Reset discards buffered
    // tags and ignores whatever upstream presents.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_dst_q   <= '0;
            out_tag_q   <= '0;
            inj_cnt_q   <= '0;
            state_q     <= IDLE;
            sc_q        <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                inj_cnt_q <= inj_cnt_q + 16'd1;
            end
            level_q    <= level_d;
            in_ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
            if (ring_in_valid) begin
                out_valid_q <= 1'b1;
                out_dst_q   <= ring_in_dst;
                out_tag_q   <= ring_in_tag;
            end else if (do_pop) begin
                out_valid_q <= 1'b1;
                out_dst_q   <= head[ENT_W-1:TAG_W];
                out_tag_q   <= head[TAG_W-1:0];
            end else begin
                out_valid_q <= 1'b0;
                out_dst_q   <= '0;
                out_tag_q   <= '0;
            end
            state_q <= state_d;
            sc_q    <= sc_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign ring_out_valid = out_valid_q;
    assign ring_out_dst   = out_dst_q;
    assign ring_out_tag   = out_tag_q;
    assign hold_req       = (state_q == HOLD);
    assign fifo_level     = level_q;
    assign inj_cnt        = inj_cnt_q;

endmodule

// File: tb/tb_egr_tagring_tx.sv
// tb_egr_tagring_tx
// Testbench for egr_tagring_tx. A queue-based reference model tracks the
// buffered tags, the expected downstream slot, the injection count and the
// starvation hold; every cycle all DUT outputs are compared with it, and a
// few directed checks pin down the notable corner cases.
module tb_egr_tagring_tx;

    localparam int TAG_W      = 32;
    localparam int DST_W      = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int STARVE_MAX = 15;
    localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

    logic             cclk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DST_W-1:0] in_dst;
    logic [TAG_W-1:0] in_tag;
    logic             ring_in_valid;
    logic [DST_W-1:0] ring_in_dst;
    logic [TAG_W-1:0] ring_in_tag;
    logic             ring_out_valid;
    logic [DST_W-1:0] ring_out_dst;
    logic [TAG_W-1:0] ring_out_tag;
    logic             hold_req;
    logic [LVL_W-1:0] fifo_level;
    logic [15:0]      inj_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DST_W+TAG_W-1:0] refQ[$];
    bit                     refReady;
    bit                     refOutValid;
    logic [DST_W-1:0]       refOutDst;
    logic [TAG_W-1:0]       refOutTag;
    logic [15:0]            refInj;
    int                     refBlocked;
    bit                     refHold;

    // Free-running core clock
    always #5 cclk = ~cclk;

    egr_tagring_tx #(
        .TAG_W(TAG_W), .DST_W(DST_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .cclk(cclk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst), .in_tag(in_tag),
        .ring_in_valid(ring_in_valid), .ring_in_dst(ring_in_dst), .ring_in_tag(ring_in_tag),
        .ring_out_valid(ring_out_valid), .ring_out_dst(ring_out_dst), .ring_out_tag(ring_out_tag),
        .hold_req(hold_req), .fifo_level(fifo_level), .inj_cnt(inj_cnt)
    );

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven
    task automatic modelStep();
        bit accept;
        bit pop;
        int sizeBefore;
        logic [DST_W+TAG_W-1:0] head;
        if (!rst_n) begin
            refQ.delete();
            refReady    = 1'b0;
            refOutValid = 1'b0;
            refOutDst   = '0;
            refOutTag   = '0;
            refInj      = '0;
            refBlocked  = 0;
            refHold     = 1'b0;
            return;
        end
        sizeBefore = refQ.size();
        accept     = in_valid && refReady;
        pop        = !ring_in_valid && (sizeBefore > 0);
        if (ring_in_valid) begin
            refOutValid = 1'b1;
            refOutDst   = ring_in_dst;
            refOutTag   = ring_in_tag;
        end else if (pop) begin
            head        = refQ.pop_front();
            refOutValid = 1'b1;
            refOutDst   = head[DST_W+TAG_W-1:TAG_W];
            refOutTag   = head[TAG_W-1:0];
            refInj      = refInj + 16'd1;
        end else begin
            refOutValid = 1'b0;
            refOutDst   = '0;
            refOutTag   = '0;
        end
        // Consecutive cycles the waiting head was denied a slot
        if (pop) begin
            refBlocked = 0;
            refHold    = 1'b0;
        end else if (sizeBefore > 0 && !refHold) begin
            refBlocked++;
            if (refBlocked == STARVE_MAX) refHold = 1'b1;
        end
        if (accept) refQ.push_back({in_dst, in_tag});
        refReady = (refQ.size() != FIFO_DEPTH);
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        checkValue("in_ready",       64'(in_ready),       64'(refReady));
        checkValue("ring_out_valid", 64'(ring_out_valid), 64'(refOutValid));
        checkValue("ring_out_dst",   64'(ring_out_dst),   64'(refOutDst));
        checkValue("ring_out_tag",   64'(ring_out_tag),   64'(refOutTag));
        checkValue("hold_req",       64'(hold_req),       64'(refHold));
        checkValue("fifo_level",     64'(fifo_level),     64'(refQ.size()));
        checkValue("inj_cnt",        64'(inj_cnt),        64'(refInj));
    endtask

    // Drive one cycle of inputs, clock it, update the model, check mid-cycle
    task automatic applyStimulus(input bit rstN, input bit rv, input logic [DST_W-1:0] rd,
                                 input logic [TAG_W-1:0] rt, input bit iv,
                                 input logic [DST_W-1:0] id, input logic [TAG_W-1:0] it);
        rst_n         = rstN;
        ring_in_valid = rv;
        ring_in_dst   = rd;
        ring_in_tag   = rt;
        in_valid      = iv;
        in_dst        = id;
        in_tag        = it;
        @(posedge cclk);
        modelStep();
        @(negedge cclk);
        checkOutput();
    endtask

    initial begin
        // Reset state
        applyStimulus(0, 0, '0, '0, 0, '0, '0);
        applyStimulus(0, 1, 5'd7, 32'h55, 1, 5'd1, 32'h1);
        checkValue("rst_ring_out_valid", 64'(ring_out_valid), 64'd0);
        checkValue("rst_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1, 0, '0, '0, 0, '0, '0);
        checkValue("ready_after_reset", 64'(in_ready), 64'd1);

        // Four tags into an empty ring: injected in order, level drains
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, '0, '0, 1, 5'd3, 32'hA0 + 32'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, '0, 0, '0, '0);
        checkValue("inj_after_4", 64'(inj_cnt), 64'd4);
        checkValue("level_after_4", 64'(fifo_level), 64'd0);

        // Upstream slots continuously occupied while tags are offered
        for (int i = 0; i < 15; i++) applyStimulus(1, 1, 5'd7, 32'h55, 1, 5'd9, 32'hB0 + 32'(i));
        checkValue("hold_before_max", 64'(hold_req), 64'd0);
        applyStimulus(1, 1, 5'd7, 32'h55, 1, 5'd9, 32'hC0);
        checkValue("hold_at_max", 64'(hold_req), 64'd1);
        checkValue("level_full", 64'(fifo_level), 64'd8);
        checkValue("ready_full", 64'(in_ready), 64'd0);
        checkValue("no_injection", 64'(inj_cnt), 64'd4);
        applyStimulus(1, 1, 5'd7, 32'h55, 1, 5'd9, 32'hC1);
        checkValue("ring_passthru", 64'(ring_out_tag), 64'h55);

        // One empty slot while full and offering: pop, no enqueue
        applyStimulus(1, 0, '0, '0, 1, 5'd9, 32'hC2);
        checkValue("head_injected", 64'(ring_out_tag), 64'hB0);
        checkValue("hold_released", 64'(hold_req), 64'd0);
        checkValue("level_after_pop", 64'(fifo_level), 64'd7);
        checkValue("ready_after_pop", 64'(in_ready), 64'd1);
        applyStimulus(1, 1, 5'd7, 32'h66, 1, 5'd9, 32'hC3);
        applyStimulus(1, 0, '0, '0, 1, 5'd9, 32'hC4);
        checkValue("level_full_pop", 64'(fifo_level), 64'd7);
        checkValue("second_head", 64'(ring_out_tag), 64'hB1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, '0, '0, 0, '0, '0);

        // Drive the injection counter through its wrap at full throughput
        for (int n = 0; n < 70000 && refInj != 16'hFFFE; n++)
            applyStimulus(1, 0, '0, '0, 1, 5'($urandom), $urandom);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, '0, 1, 5'($urandom), $urandom);
        checkValue("inj_wrapped", 64'(inj_cnt), 64'h0001);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, '0, '0, 0, '0, '0);

        // Reset with buffered tags and occupied upstream slot
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 5'd2, 32'h77, 1, 5'd4, 32'hD0 + 32'(i));
        checkValue("level_five", 64'(fifo_level), 64'd5);
        applyStimulus(0, 1, 5'd2, 32'h77, 0, '0, '0);
        checkValue("rst_flush_level", 64'(fifo_level), 64'd0);
        checkValue("rst_flush_valid", 64'(ring_out_valid), 64'd0);
        checkValue("rst_flush_inj", 64'(inj_cnt), 64'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, '0, '0, 0, '0, '0);
        checkValue("flushed_never_injected", 64'(inj_cnt), 64'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                          $urandom_range(0, 3) != 0, 5'($urandom), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
